health_ctrl: RTL

HEALTH_CTRL -- requirements
Module: health_ctrl

---
 rtl/health_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/health_ctrl.sv
// Player health controller: round-robin hit arbitration, invulnerability window after
// each accepted hit, and a game-over state left only through a start request.
module health_ctrl #(
    parameter int unsigned HP_INIT      = 3,
    parameter int unsigned INVULN_TICKS = 90
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] hit_req,
    input  logic       start,
    output logic [3:0] hp_dig,
    output logic [3:0] hit_grant,
    output logic       invuln,
    output logic       game_over,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        StPlay   = 2'd0,
        StInvuln = 2'd1,
        StOver   = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] hp_q, hp_d;
    logic [3:0] grant_q, grant_d;
    logic [3:0] pending_q, pending_d;
    logic [3:0] prev_req_q, prev_req_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0] inv_cnt_q, inv_cnt_d;
    logic       invuln_q, invuln_d;
    logic       game_over_q, game_over_d;

    logic [3:0] rise;
    logic       found;
    logic [1:0] win_idx;
    logic [1:0] idx;
    logic       accept;
    logic [3:0] grant_now;
    logic [3:0] hp_dec;

    assign rise = hit_req & ~prev_req_q;

    // Round-robin search starting at rr_ptr_q, ascending modulo 4.
    always_comb begin
        found   = 1'b0;
        win_idx = 2'd0;
        idx     = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr_q + 2'(k);
            if (!found && pending_q[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

    assign accept    = (state_q == StPlay) && found && (hp_q != 4'd0);
    assign grant_now = accept ? (4'b0001 << win_idx) : 4'b0000;
    assign hp_dec    = hp_q - 4'd1;

    always_comb begin
        state_d    = state_q;
        hp_d       = hp_q;
        grant_d    = 4'b0000;
        pending_d  = 4'b0000;
        prev_req_d = hit_req;
        rr_ptr_d   = rr_ptr_q;
        inv_cnt_d  = inv_cnt_q;

        unique case (state_q)
            StPlay: begin
                pending_d = (pending_q | rise) & ~grant_now;
                if (accept) begin
                    grant_d  = grant_now;
                    hp_d     = hp_dec;
                    rr_ptr_d = win_idx + 2'd1;
                    if (hp_dec == 4'd0) begin
                        state_d = StOver;
                    end else begin
                        state_d   = StInvuln;
                        inv_cnt_d = 8'(INVULN_TICKS);
                    end
                end
            end
            StInvuln: begin
                if (tick) begin
                    inv_cnt_d = inv_cnt_q - 8'd1;
                    if (inv_cnt_q == 8'd1) begin
                        state_d = StPlay;
                    end
                end
            end
            StOver: begin
                hp_d = 4'd0;
                if (start) begin
                    state_d  = StPlay;
                    hp_d     = 4'(HP_INIT);
                    rr_ptr_d = 2'd0;
                end
            end
            default: begin
                state_d = StPlay;
            end
        endcase

        invuln_d    = (state_d == StInvuln);
        game_over_d = (state_d == StOver);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StPlay;
            hp_q        <= 4'(HP_INIT);
            grant_q     <= 4'b0000;
            pending_q   <= 4'b0000;
            prev_req_q  <= 4'b0000;
            rr_ptr_q    <= 2'd0;
            inv_cnt_q   <= 8'd0;
            invuln_q    <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hp_q        <= hp_d;
            grant_q     <= grant_d;
            pending_q   <= pending_d;
            prev_req_q  <= prev_req_d;
            rr_ptr_q    <= rr_ptr_d;
            inv_cnt_q   <= inv_cnt_d;
            invuln_q    <= invuln_d;
            game_over_q <= game_over_d;
        end
    end

    assign hp_dig    = hp_q;
    assign hit_grant = grant_q;
    assign invuln    = invuln_q;
    assign game_over = game_over_q;
    assign state     = state_q;

endmodule
